// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one MemoryBus port among NUM_REQ clients
// (0 = fetch, 1 = load, 2 = store). Round-robin grant, one transaction
// outstanding, response routed back only to the issuing requester.
// Optional feature macro: MEM_ARB_TIMEOUT_EN (response timeout after
// TIMEOUT_CYC cycles in WAIT_RSP, delivered with rsp_error = 1).
module mem_bus_arbiter #(
    parameter int NUM_REQ     = 3,
    parameter int ID_W        = 8,
    parameter int TIMEOUT_CYC = 1023
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [NUM_REQ-1:0]             req_write,
    input  logic [NUM_REQ-1:0][63:0]       req_addr,
    input  logic [NUM_REQ-1:0][63:0]       req_wdata,
    input  logic [NUM_REQ-1:0][ID_W-1:0]   req_id,
    output logic [NUM_REQ-1:0]             req_ready,
    output logic [NUM_REQ-1:0]             rsp_valid,
    output logic [63:0]                    rsp_data,
    output logic                           rsp_error,
    output logic                           mem_req_valid,
    input  logic                           mem_req_ready,
    output logic                           mem_req_write,
    output logic [63:0]                    mem_req_addr,
    output logic [63:0]                    mem_req_wdata,
    output logic [ID_W-1:0]                mem_req_id,
    input  logic                           mem_rsp_valid,
    input  logic [63:0]                    mem_rsp_data,
    input  logic [ID_W-1:0]                mem_rsp_id,
    output logic                           busy
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ISSUE    = 2'd1,
        WAIT_RSP = 2'd2,
        DELIVER  = 2'd3
    } state_t;

    // Request captured at grant time and replayed unchanged to memory.
    typedef struct packed {
        logic            write;
        logic [63:0]     addr;
        logic [63:0]     wdata;
        logic [ID_W-1:0] id;
    } mem_req_t;

    state_t           state_q,  state_d;
    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0] owner_q,  owner_d;
    mem_req_t         req_q,    req_d;
    logic [63:0]      data_q,   data_d;

    logic             grant_found;
    logic [IDX_W-1:0] grant_idx;
    logic             rsp_match;

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYC != 0);
`endif

    // Round-robin search starting at rr_ptr; first pending requester wins.
    always_comb begin
        int j;
        grant_found = 1'b0;
        grant_idx   = '0;
        j           = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            j = (int'(rr_ptr_q) + i) % NUM_REQ;
            if (!grant_found && req_valid[j]) begin
                grant_found = 1'b1;
                grant_idx   = IDX_W'(j);
            end
        end
    end

    assign rsp_match = mem_rsp_valid && (mem_rsp_id == req_q.id);

    // Next-state logic and request/response latching.
    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        owner_d  = owner_q;
        req_d    = req_q;
        data_d   = data_q;
`ifdef MEM_ARB_TIMEOUT_EN
        cnt_d    = cnt_q;
        err_d    = err_q;
`endif
        case (state_q)
            IDLE: begin
                if (grant_found) begin
                    req_d.write = req_write[grant_idx];
                    req_d.addr  = {req_addr[grant_idx][63:3], 3'b000};
                    req_d.wdata = req_wdata[grant_idx];
                    req_d.id    = req_id[grant_idx];
                    owner_d     = grant_idx;
                    rr_ptr_d    = (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0
                                                                     : grant_idx + IDX_W'(1);
                    data_d      = '0;
`ifdef MEM_ARB_TIMEOUT_EN
                    err_d       = 1'b0;
`endif
                    state_d     = ISSUE;
                end
            end
            ISSUE: begin
                if (mem_req_ready) begin
`ifdef MEM_ARB_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                    state_d = WAIT_RSP;
                end
            end
            WAIT_RSP: begin
                // A matching response beats a timeout in the same cycle.
                if (rsp_match) begin
                    data_d  = mem_rsp_data;
                    state_d = DELIVER;
                end
`ifdef MEM_ARB_TIMEOUT_EN
                else if (cnt_q + CNT_W'(1) == CNT_W'(TIMEOUT_CYC)) begin
                    data_d  = '0;
                    err_d   = 1'b1;
                    state_d = DELIVER;
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                end
`endif
            end
            DELIVER: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State and latch registers; reset abandons any transaction in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            owner_q  <= '0;
            req_q    <= '0;
            data_q   <= '0;
`ifdef MEM_ARB_TIMEOUT_EN
            cnt_q    <= '0;
            err_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            owner_q  <= owner_d;
            req_q    <= req_d;
            data_q   <= data_d;
`ifdef MEM_ARB_TIMEOUT_EN
            cnt_q    <= cnt_d;
            err_q    <= err_d;
`endif
        end
    end

    // Per-requester grant and response strobes; grant is gated by reset so
    // all outputs read 0 while reset is held.
    for (genvar g = 0; g < NUM_REQ; g++) begin : g_lane
        assign req_ready[g] = !reset && (state_q == IDLE) && grant_found &&
                              (grant_idx == IDX_W'(g));
        assign rsp_valid[g] = (state_q == DELIVER) && (owner_q == IDX_W'(g));
    end

    assign mem_req_valid = (state_q == ISSUE);
    assign mem_req_write = req_q.write;
    assign mem_req_addr  = req_q.addr;
    assign mem_req_wdata = req_q.wdata;
    assign mem_req_id    = req_q.id;
    assign rsp_data      = data_q;
    assign busy          = (state_q != IDLE);

`ifdef MEM_ARB_TIMEOUT_EN
    assign rsp_error = err_q;
`else
    assign rsp_error = 1'b0;
`endif

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: a round-robin vector table plus
// hand-written sequences for single read, backpressure, id filtering,
// reset mid-transaction and (when MEM_ARB_TIMEOUT_EN is set) timeout.
module tb_mem_bus_arbiter;
    localparam int NUM_REQ = 3;
    localparam int ID_W    = 8;

    logic                         clk = 1'b0;
    logic                         reset = 1'b1;
    logic [NUM_REQ-1:0]           req_valid, req_write, req_ready, rsp_valid;
    logic [NUM_REQ-1:0][63:0]     req_addr, req_wdata;
    logic [NUM_REQ-1:0][ID_W-1:0] req_id;
    logic [63:0]                  rsp_data, mem_req_addr, mem_req_wdata, mem_rsp_data;
    logic                         rsp_error, mem_req_valid, mem_req_ready, mem_req_write;
    logic [ID_W-1:0]              mem_req_id, mem_rsp_id;
    logic                         mem_rsp_valid, busy;

    mem_bus_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W), .TIMEOUT_CYC(16)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_id(req_id), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_error(rsp_error),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_req_write(mem_req_write), .mem_req_addr(mem_req_addr),
        .mem_req_wdata(mem_req_wdata), .mem_req_id(mem_req_id),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
        .mem_rsp_id(mem_rsp_id), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] valid;
        logic [2:0] exp_grant;
    } vec_t;

    vec_t vecs[11];
    int   n_checks = 0;
    int   n_err    = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic clear_inputs();
        req_valid     = '0;
        req_write     = '0;
        req_addr      = '0;
        req_wdata     = '0;
        req_id        = '0;
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0;
        mem_rsp_data  = '0;
        mem_rsp_id    = '0;
    endtask

    // One full transaction with memory latency 1; requester fields already driven.
    task automatic run_txn(input logic [2:0] valid, input logic [2:0] exp_grant,
                           input logic [63:0] data);
        int lane;
        lane = 0;
        for (int i = 0; i < NUM_REQ; i++) if (exp_grant[i]) lane = i;
        req_valid = valid;
        #1;
        chk("grant", req_ready, exp_grant);
        chk("busy_idle", busy, 0);
        tick();
        chk("no_grant_in_issue", req_ready, 0);
        chk("mem_req_valid", mem_req_valid, 1);
        chk("mem_req_addr", mem_req_addr, req_addr[lane] & ~64'h7);
        chk("mem_req_id", mem_req_id, req_id[lane]);
        chk("mem_req_write", mem_req_write, req_write[lane]);
        chk("mem_req_wdata", mem_req_wdata, req_wdata[lane]);
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        chk("mem_req_drop", mem_req_valid, 0);
        mem_rsp_valid = 1'b1;
        mem_rsp_id    = req_id[lane];
        mem_rsp_data  = data;
        tick();
        mem_rsp_valid = 1'b0;
        #1;
        chk("rsp_valid", rsp_valid, exp_grant);
        chk("rsp_data", rsp_data, data);
        chk("rsp_error", rsp_error, 0);
        req_valid = '0;
        tick();
        chk("rsp_valid_pulse", rsp_valid, 0);
        chk("busy_back_idle", busy, 0);
    endtask

    initial begin
        // Grant order starting from rr_ptr = 0 after reset.
        vecs[0]  = '{3'b111, 3'b001};
        vecs[1]  = '{3'b111, 3'b010};
        vecs[2]  = '{3'b111, 3'b100};
        vecs[3]  = '{3'b111, 3'b001};
        vecs[4]  = '{3'b111, 3'b010};
        vecs[5]  = '{3'b111, 3'b100};
        vecs[6]  = '{3'b110, 3'b010};
        vecs[7]  = '{3'b011, 3'b001};
        vecs[8]  = '{3'b100, 3'b100};
        vecs[9]  = '{3'b101, 3'b001};
        vecs[10] = '{3'b101, 3'b100};

        clear_inputs();
        req_valid = 3'b111;
        reset     = 1'b1;
        tick();
        tick();
        #1;
        chk("rst_req_ready", req_ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_mem_req_valid", mem_req_valid, 0);
        chk("rst_mem_req_addr", mem_req_addr, 0);
        chk("rst_mem_req_id", mem_req_id, 0);
        chk("rst_rsp_data", rsp_data, 0);
        chk("rst_rsp_error", rsp_error, 0);
        chk("rst_busy", busy, 0);
        req_valid = '0;
        reset     = 1'b0;
        tick();

        // Round-robin table.
        for (int e = 0; e < 11; e++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                req_addr[i]  = 64'h4000 + 64'(e << 8) + 64'(i << 4) + 64'(i + 5);
                req_id[i]    = 8'(8'h10 + e * 4 + i);
                req_wdata[i] = 64'hA000 + 64'(e << 4) + 64'(i);
            end
            req_write = 3'b100;
            run_txn(vecs[e].valid, vecs[e].exp_grant, 64'hC0DE_0000 + 64'(e));
        end

        // Single read: fetch, addr 0x1003, response 5 cycles later.
        clear_inputs();
        req_addr[0] = 64'h1003;
        req_id[0]   = 8'h01;
        req_valid   = 3'b001;
        #1;
        chk("sr_grant", req_ready, 3'b001);
        tick();
        req_valid     = '0;
        mem_req_ready = 1'b1;
        chk("sr_mem_req_addr", mem_req_addr, 64'h1000);
        chk("sr_mem_req_write", mem_req_write, 0);
        tick();
        mem_req_ready = 1'b0;
        for (int c = 0; c < 4; c++) begin
            chk("sr_wait_no_rsp", rsp_valid, 0);
            tick();
        end
        mem_rsp_valid = 1'b1;
        mem_rsp_id    = 8'h01;
        mem_rsp_data  = 64'hDEADBEEF_00000001;
        #1;
        chk("sr_rsp_not_same_cycle", rsp_valid, 0);
        tick();
        mem_rsp_valid = 1'b0;
        #1;
        chk("sr_rsp_valid", rsp_valid, 3'b001);
        chk("sr_rsp_data", rsp_data, 64'hDEADBEEF_00000001);
        chk("sr_rsp_error", rsp_error, 0);
        tick();
        chk("sr_rsp_one_cycle", rsp_valid, 0);

        // Backpressure: store write of 0x55 to 0x2000, 7 cycles not ready.
        clear_inputs();
        req_write[2] = 1'b1;
        req_addr[2]  = 64'h2000;
        req_wdata[2] = 64'h55;
        req_id[2]    = 8'h03;
        req_valid    = 3'b100;
        #1;
        chk("bp_grant", req_ready, 3'b100);
        tick();
        req_valid = '0;
        for (int c = 0; c < 8; c++) begin
            chk("bp_mem_req_valid", mem_req_valid, 1);
            chk("bp_mem_req_addr", mem_req_addr, 64'h2000);
            chk("bp_mem_req_wdata", mem_req_wdata, 64'h55);
            chk("bp_mem_req_write", mem_req_write, 1);
            chk("bp_mem_req_id", mem_req_id, 8'h03);
            if (c == 7) mem_req_ready = 1'b1;
            tick();
        end
        mem_req_ready = 1'b0;
        chk("bp_mem_req_drop", mem_req_valid, 0);
        mem_rsp_valid = 1'b1;
        mem_rsp_id    = 8'h03;
        tick();
        mem_rsp_valid = 1'b0;
        #1;
        chk("bp_ack_rsp_valid", rsp_valid, 3'b100);
        tick();
        chk("bp_ack_one_cycle", rsp_valid, 0);

        // Id filtering: waiting on id 0x02, memory sends 0x07 then 0x02.
        clear_inputs();
        req_addr[1] = 64'h3008;
        req_id[1]   = 8'h02;
        req_valid   = 3'b010;
        #1;
        chk("idf_grant", req_ready, 3'b010);
        tick();
        req_valid     = '0;
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b1;
        mem_rsp_id    = 8'h07;
        mem_rsp_data  = 64'h1111;
        tick();
        chk("idf_foreign_ignored", rsp_valid, 0);
        chk("idf_still_busy", busy, 1);
        mem_rsp_id   = 8'h02;
        mem_rsp_data = 64'h2222;
        tick();
        mem_rsp_valid = 1'b0;
        #1;
        chk("idf_rsp_valid", rsp_valid, 3'b010);
        chk("idf_rsp_data", rsp_data, 64'h2222);
        tick();
        chk("idf_single_pulse", rsp_valid, 0);
        tick();
        chk("idf_no_second_pulse", rsp_valid, 0);

        // Reset in WAIT_RSP: rr_ptr moved to 2 by this grant, reset returns it to 0.
        clear_inputs();
        req_addr[1] = 64'h3010;
        req_id[1]   = 8'h02;
        req_valid   = 3'b010;
        #1;
        chk("rm_grant", req_ready, 3'b010);
        tick();
        req_valid     = '0;
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        chk("rm_in_wait", busy, 1);
        reset = 1'b1;
        #1;
        chk("rm_busy_async", busy, 0);
        chk("rm_mem_req_addr", mem_req_addr, 0);
        chk("rm_mem_req_id", mem_req_id, 0);
        chk("rm_rsp_valid", rsp_valid, 0);
        tick();
        reset         = 1'b0;
        mem_rsp_valid = 1'b1;
        mem_rsp_id    = 8'h02;
        mem_rsp_data  = 64'h9999;
        tick();
        mem_rsp_valid = 1'b0;
        chk("rm_stale_rsp_dropped", rsp_valid, 0);
        tick();
        chk("rm_stale_rsp_dropped2", rsp_valid, 0);
        for (int i = 0; i < NUM_REQ; i++) begin
            req_addr[i] = 64'h5000 + 64'(i << 3);
            req_id[i]   = 8'(8'h20 + i);
        end
        run_txn(3'b111, 3'b001, 64'h7777);

`ifdef MEM_ARB_TIMEOUT_EN
        // Timeout after 16 cycles in WAIT_RSP; late response ignored.
        clear_inputs();
        req_addr[0] = 64'h6000;
        req_id[0]   = 8'h05;
        req_valid   = 3'b001;
        #1;
        chk("to_grant", req_ready, 3'b001);
        tick();
        req_valid     = '0;
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        for (int c = 0; c < 16; c++) begin
            chk("to_wait_no_rsp", rsp_valid, 0);
            tick();
        end
        chk("to_rsp_valid", rsp_valid, 3'b001);
        chk("to_rsp_error", rsp_error, 1);
        chk("to_rsp_data", rsp_data, 0);
        mem_rsp_valid = 1'b1;
        mem_rsp_id    = 8'h05;
        mem_rsp_data  = 64'hBAD;
        tick();
        chk("to_late_ignored", rsp_valid, 0);
        tick();
        mem_rsp_valid = 1'b0;
        chk("to_late_ignored2", rsp_valid, 0);
        chk("to_idle", busy, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
